hex_scan_ctrl: RTL and testbench



---
 rtl/hex_scan_ctrl.sv | 143 ++++++++++++++
 tb/tb_hex_scan_ctrl.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hex_scan_ctrl.sv
// Eight-digit active-low 7-segment controller: a loaded 32-bit value is scanned
// one nibble per cycle through a single shared decoder into per-digit registers.
module hex_scan_ctrl #(
    parameter int BLANK_LZ  = 1,
    parameter int BLINK_DIV = 25000000,
    parameter int CNT_W     = 25
) (
    input  logic        CLOCK_50,
    input  logic        RESET_N,
    input  logic [31:0] DATA,
    input  logic        LOAD,
    output logic        BUSY,
    output logic        DONE,
    output logic        DROP,
    input  logic        BLINK_EN,
    input  logic [7:0]  DIGIT_MASK,
    output logic [6:0]  HEX0,
    output logic [6:0]  HEX1,
    output logic [6:0]  HEX2,
    output logic [6:0]  HEX3,
    output logic [6:0]  HEX4,
    output logic [6:0]  HEX5,
    output logic [6:0]  HEX6,
    output logic [6:0]  HEX7,
    output logic        DBG_SCAN
);

    // Handshake: LOAD is sampled on every rising edge. It is accepted only in IDLE;
    // a LOAD seen while scanning is discarded and answered with a one-cycle DROP.
    // BUSY covers the whole scan, and DONE pulses in the first IDLE cycle after it.
    typedef enum logic {IDLE = 1'b0, SCAN = 1'b1} state_t;

    state_t             state;
    logic [2:0]         idx;
    logic [31:0]        shadow;
    logic               nz;
    logic [6:0]         digit [8];
    logic [CNT_W-1:0]   cnt;
    logic               blank_ph;
    logic [3:0]         nib;
    logic [6:0]         seg;
    logic [6:0]         wr_val;
    logic               lz_blank;
    logic               hide;

    assign nib = shadow[{idx, 2'b00} +: 4];

    always_comb begin
        seg = 7'h7F;
        case (nib)
            4'h0: seg = 7'h40;
            4'h1: seg = 7'h79;
            4'h2: seg = 7'h24;
            4'h3: seg = 7'h30;
            4'h4: seg = 7'h19;
            4'h5: seg = 7'h12;
            4'h6: seg = 7'h02;
            4'h7: seg = 7'h78;
            4'h8: seg = 7'h00;
            4'h9: seg = 7'h10;
            4'hA: seg = 7'h08;
            4'hB: seg = 7'h03;
            4'hC: seg = 7'h46;
            4'hD: seg = 7'h21;
            4'hE: seg = 7'h06;
            4'hF: seg = 7'h0E;
            default: seg = 7'h7F;
        endcase
    end

    // HEX0 is never blanked so an all-zero value still reads "0".
    assign lz_blank = (BLANK_LZ != 0) && !nz && (nib == 4'h0) && (idx != 3'd0);
    assign wr_val   = lz_blank ? 7'h7F : seg;

    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            state  <= IDLE;
            idx    <= 3'd7;
            shadow <= 32'h0;
            nz     <= 1'b0;
            BUSY   <= 1'b0;
            DONE   <= 1'b0;
            DROP   <= 1'b0;
            for (int k = 0; k < 8; k++) digit[k] <= 7'h7F;
        end else begin
            DONE <= 1'b0;
            DROP <= 1'b0;
            case (state)
                IDLE: begin
                    if (LOAD) begin
                        shadow <= DATA;
                        nz     <= 1'b0;
                        idx    <= 3'd7;
                        BUSY   <= 1'b1;
                        state  <= SCAN;
                    end
                end
                SCAN: begin
                    if (LOAD) DROP <= 1'b1;
                    digit[idx] <= wr_val;
                    if (nib != 4'h0) nz <= 1'b1;
                    if (idx == 3'd0) begin
                        BUSY  <= 1'b0;
                        DONE  <= 1'b1;
                        state <= IDLE;
                    end else begin
                        idx <= idx - 3'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            cnt      <= '0;
            blank_ph <= 1'b0;
        end else if (!BLINK_EN) begin
            cnt      <= '0;
            blank_ph <= 1'b0;
        end else if (cnt == CNT_W'(BLINK_DIV - 1)) begin
            cnt      <= '0;
            blank_ph <= ~blank_ph;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    // Gating the phase with BLINK_EN lets a disable take effect in the same cycle.
    assign hide     = BLINK_EN & blank_ph;
    assign DBG_SCAN = (state == SCAN);

    assign HEX0 = (DIGIT_MASK[0] | hide) ? 7'h7F : digit[0];
    assign HEX1 = (DIGIT_MASK[1] | hide) ? 7'h7F : digit[1];
    assign HEX2 = (DIGIT_MASK[2] | hide) ? 7'h7F : digit[2];
    assign HEX3 = (DIGIT_MASK[3] | hide) ? 7'h7F : digit[3];
    assign HEX4 = (DIGIT_MASK[4] | hide) ? 7'h7F : digit[4];
    assign HEX5 = (DIGIT_MASK[5] | hide) ? 7'h7F : digit[5];
    assign HEX6 = (DIGIT_MASK[6] | hide) ? 7'h7F : digit[6];
    assign HEX7 = (DIGIT_MASK[7] | hide) ? 7'h7F : digit[7];

endmodule

// File: tb/tb_hex_scan_ctrl.sv
// Bench for hex_scan_ctrl: two instances (leading-zero blanking off and on) share
// stimulus; completed scans are scored against per-instance expected queues.
module tb_hex_scan_ctrl;

    localparam logic [55:0] ALL_BLANK = {8{7'h7F}};

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] data;
    logic        load;
    logic        blink_en;
    logic [7:0]  mask;

    logic        busy0, done0, drop0, dbg0;
    logic        busy1, done1, drop1, dbg1;
    logic [6:0]  a_hex [8];
    logic [6:0]  b_hex [8];
    logic [55:0] a_all, b_all;

    int          chk_cnt  = 0;
    int          pass_cnt = 0;
    logic [55:0] exp_q0 [$];
    logic [55:0] exp_q1 [$];
    logic [55:0] last0 = ALL_BLANK;
    logic [55:0] last1 = ALL_BLANK;

    assign a_all = {a_hex[7], a_hex[6], a_hex[5], a_hex[4], a_hex[3], a_hex[2], a_hex[1], a_hex[0]};
    assign b_all = {b_hex[7], b_hex[6], b_hex[5], b_hex[4], b_hex[3], b_hex[2], b_hex[1], b_hex[0]};

    hex_scan_ctrl #(.BLANK_LZ(0), .BLINK_DIV(4), .CNT_W(3)) dut0 (
        .CLOCK_50(clk), .RESET_N(rst_n), .DATA(data), .LOAD(load),
        .BUSY(busy0), .DONE(done0), .DROP(drop0), .BLINK_EN(blink_en), .DIGIT_MASK(mask),
        .HEX0(a_hex[0]), .HEX1(a_hex[1]), .HEX2(a_hex[2]), .HEX3(a_hex[3]),
        .HEX4(a_hex[4]), .HEX5(a_hex[5]), .HEX6(a_hex[6]), .HEX7(a_hex[7]),
        .DBG_SCAN(dbg0)
    );

    hex_scan_ctrl #(.BLANK_LZ(1), .BLINK_DIV(4), .CNT_W(3)) dut1 (
        .CLOCK_50(clk), .RESET_N(rst_n), .DATA(data), .LOAD(load),
        .BUSY(busy1), .DONE(done1), .DROP(drop1), .BLINK_EN(blink_en), .DIGIT_MASK(mask),
        .HEX0(b_hex[0]), .HEX1(b_hex[1]), .HEX2(b_hex[2]), .HEX3(b_hex[3]),
        .HEX4(b_hex[4]), .HEX5(b_hex[5]), .HEX6(b_hex[6]), .HEX7(b_hex[7]),
        .DBG_SCAN(dbg1)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    function automatic logic [6:0] seg_ref(input logic [3:0] n);
        case (n)
            4'h0: return 7'h40;  4'h1: return 7'h79;  4'h2: return 7'h24;  4'h3: return 7'h30;
            4'h4: return 7'h19;  4'h5: return 7'h12;  4'h6: return 7'h02;  4'h7: return 7'h78;
            4'h8: return 7'h00;  4'h9: return 7'h10;  4'hA: return 7'h08;  4'hB: return 7'h03;
            4'hC: return 7'h46;  4'hD: return 7'h21;  4'hE: return 7'h06;  default: return 7'h0E;
        endcase
    endfunction

    function automatic logic [55:0] model(input logic [31:0] d, input bit lz);
        logic [55:0] r;
        logic [3:0]  n;
        bit          seen;
        r    = '0;
        seen = 1'b0;
        for (int k = 7; k >= 0; k--) begin
            n = d[k*4 +: 4];
            if (n != 4'h0) seen = 1'b1;
            r[k*7 +: 7] = (lz && !seen && k != 0) ? 7'h7F : seg_ref(n);
        end
        return r;
    endfunction

    function automatic logic [55:0] apply_mask(input logic [55:0] v, input logic [7:0] m);
        logic [55:0] r;
        r = v;
        for (int k = 0; k < 8; k++) if (m[k]) r[k*7 +: 7] = 7'h7F;
        return r;
    endfunction

    // ---------------- scoreboard ----------------
    always @(negedge clk) begin
        if (rst_n) begin
            if (done0) begin
                chk_cnt++;
                if (exp_q0.size() == 0) begin
                    $display("FAIL sb0_unexpected_done: got DONE with empty queue, want none");
                end else begin
                    last0 = exp_q0.pop_front();
                    if (a_all !== last0) $display("FAIL sb0_digits: got %h want %h", a_all, last0);
                    else pass_cnt++;
                end
            end
            if (done1) begin
                chk_cnt++;
                if (exp_q1.size() == 0) begin
                    $display("FAIL sb1_unexpected_done: got DONE with empty queue, want none");
                end else begin
                    last1 = exp_q1.pop_front();
                    if (b_all !== last1) $display("FAIL sb1_digits: got %h want %h", b_all, last1);
                    else pass_cnt++;
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic start_load(input logic [31:0] d);
        data = d;
        load = 1'b1;
        exp_q0.push_back(model(d, 1'b0));
        exp_q1.push_back(model(d, 1'b1));
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        while (!done0 && n < 20) begin
            step();
            n++;
        end
        chk_cnt++;
        if (!done0) $display("FAIL done_timeout: got no DONE in %0d cycles, want DONE", n);
        else pass_cnt++;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst_n = 1'b0; data = '0; load = 1'b0; blink_en = 1'b0; mask = '0;
        repeat (2) step();
        rst_n = 1'b1;
        step();
        chk_cnt++; if (a_all !== ALL_BLANK) $display("FAIL reset_hex0: got %h want %h", a_all, ALL_BLANK); else pass_cnt++;
        chk_cnt++; if (b_all !== ALL_BLANK) $display("FAIL reset_hex1: got %h want %h", b_all, ALL_BLANK); else pass_cnt++;
        chk_cnt++; if ({busy0, done0, drop0} !== 3'b000) $display("FAIL reset_flags: got %b want 000", {busy0, done0, drop0}); else pass_cnt++;
        chk_cnt++; if (dbg0 !== 1'b0) $display("FAIL reset_state: got %b want 0", dbg0); else pass_cnt++;
    endtask

    task automatic test_scan_order();
        start_load(32'h0123_ABCF);
        step();
        load = 1'b0;
        chk_cnt++; if (busy0 !== 1'b1) $display("FAIL busy_e0: got %b want 1", busy0); else pass_cnt++;
        chk_cnt++; if (a_hex[7] !== 7'h7F) $display("FAIL hex7_e0: got %h want 7f", a_hex[7]); else pass_cnt++;
        step();
        chk_cnt++; if (a_hex[7] !== 7'h40) $display("FAIL hex7_e1: got %h want 40", a_hex[7]); else pass_cnt++;
        chk_cnt++; if (a_hex[6] !== 7'h7F) $display("FAIL hex6_e1: got %h want 7f", a_hex[6]); else pass_cnt++;
        chk_cnt++; if (dbg0 !== 1'b1) $display("FAIL state_e1: got %b want 1", dbg0); else pass_cnt++;
        for (int i = 2; i <= 7; i++) begin
            step();
            chk_cnt++;
            if (busy0 !== 1'b1 || done0 !== 1'b0) $display("FAIL busy_e%0d: got busy=%b done=%b want 1 0", i, busy0, done0);
            else pass_cnt++;
        end
        step();
        chk_cnt++; if (busy0 !== 1'b0 || done0 !== 1'b1) $display("FAIL done_e8: got busy=%b done=%b want 0 1", busy0, done0); else pass_cnt++;
        step();
        chk_cnt++; if (done0 !== 1'b0) $display("FAIL done_e9: got %b want 0", done0); else pass_cnt++;
        chk_cnt++; if (a_all !== {7'h40, 7'h79, 7'h24, 7'h30, 7'h08, 7'h03, 7'h46, 7'h0E})
            $display("FAIL final_0123abcf: got %h want 40792430080346 0e", a_all); else pass_cnt++;
    endtask

    task automatic test_blank_lz();
        start_load(32'h0000_0305);
        step();
        load = 1'b0;
        wait_done();
        chk_cnt++; if (b_hex[7] !== 7'h7F || b_hex[3] !== 7'h7F) $display("FAIL lz_305_upper: got %h %h want 7f 7f", b_hex[7], b_hex[3]); else pass_cnt++;
        chk_cnt++; if ({b_hex[2], b_hex[1], b_hex[0]} !== {7'h30, 7'h40, 7'h12})
            $display("FAIL lz_305_lower: got %h %h %h want 30 40 12", b_hex[2], b_hex[1], b_hex[0]); else pass_cnt++;
        step();
        start_load(32'h0);
        step();
        load = 1'b0;
        wait_done();
        chk_cnt++; if (b_hex[0] !== 7'h40 || b_hex[1] !== 7'h7F) $display("FAIL lz_zero: got %h %h want 40 7f", b_hex[0], b_hex[1]); else pass_cnt++;
        chk_cnt++; if (a_hex[7] !== 7'h40) $display("FAIL nolz_zero: got %h want 40", a_hex[7]); else pass_cnt++;
        step();
    endtask

    task automatic test_back_to_back();
        start_load(32'h1111_1111);
        step();
        load = 1'b0;
        step();
        step();
        data = 32'h2222_2222;
        load = 1'b1;
        step();
        load = 1'b0;
        chk_cnt++; if (drop0 !== 1'b1 || drop1 !== 1'b1) $display("FAIL drop_pulse: got %b %b want 1 1", drop0, drop1); else pass_cnt++;
        step();
        chk_cnt++; if (drop0 !== 1'b0) $display("FAIL drop_width: got %b want 0", drop0); else pass_cnt++;
        wait_done();
        chk_cnt++; if (a_all !== {8{7'h79}}) $display("FAIL drop_ignored: got %h want all 79", a_all); else pass_cnt++;
        start_load(32'h2222_2222);
        step();
        load = 1'b0;
        chk_cnt++; if (busy0 !== 1'b1 || done0 !== 1'b0) $display("FAIL b2b_accept: got busy=%b done=%b want 1 0", busy0, done0); else pass_cnt++;
        wait_done();
        step();
    endtask

    task automatic test_blink();
        logic [55:0] e0, e1;
        blink_en = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            step();
            e0 = ((k / 4) % 2 == 1) ? ALL_BLANK : last0;
            e1 = ((k / 4) % 2 == 1) ? ALL_BLANK : last1;
            chk_cnt++; if (a_all !== e0) $display("FAIL blink0_k%0d: got %h want %h", k, a_all, e0); else pass_cnt++;
            chk_cnt++; if (b_all !== e1) $display("FAIL blink1_k%0d: got %h want %h", k, b_all, e1); else pass_cnt++;
        end
        blink_en = 1'b0;
        #1;
        chk_cnt++; if (a_all !== last0) $display("FAIL blink_off_now: got %h want %h", a_all, last0); else pass_cnt++;
        step();
        chk_cnt++; if (a_all !== last0) $display("FAIL blink_off_next: got %h want %h", a_all, last0); else pass_cnt++;
    endtask

    task automatic test_mask();
        logic [7:0] m;
        mask = 8'hF0;
        #1;
        chk_cnt++; if (a_all !== apply_mask(last0, 8'hF0)) $display("FAIL mask_f0: got %h want %h", a_all, apply_mask(last0, 8'hF0)); else pass_cnt++;
        chk_cnt++; if (a_hex[7] !== 7'h7F || a_hex[3] !== 7'h24) $display("FAIL mask_f0_digits: got %h %h want 7f 24", a_hex[7], a_hex[3]); else pass_cnt++;
        for (int i = 0; i < 4; i++) begin
            m = 8'($urandom_range(0, 255));
            mask = m;
            step();
            chk_cnt++; if (b_all !== apply_mask(last1, m)) $display("FAIL mask_rand_%h: got %h want %h", m, b_all, apply_mask(last1, m)); else pass_cnt++;
        end
        mask = 8'h00;
        #1;
        chk_cnt++; if (a_all !== last0) $display("FAIL mask_clear: got %h want %h", a_all, last0); else pass_cnt++;
    endtask

    task automatic test_reset_mid_scan();
        step();
        start_load(32'h1234_5678);
        step();
        load = 1'b0;
        repeat (3) step();
        rst_n = 1'b0;
        exp_q0.delete();
        exp_q1.delete();
        #1;
        chk_cnt++; if (a_all !== ALL_BLANK || b_all !== ALL_BLANK) $display("FAIL midrst_blank: got %h %h want all 7f", a_all, b_all); else pass_cnt++;
        chk_cnt++; if (busy0 !== 1'b0) $display("FAIL midrst_busy: got %b want 0", busy0); else pass_cnt++;
        repeat (2) step();
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk_cnt++;
            if (done0 !== 1'b0 || busy0 !== 1'b0) $display("FAIL midrst_quiet_%0d: got done=%b busy=%b want 0 0", i, done0, busy0);
            else pass_cnt++;
        end
        start_load(32'h8888_8888);
        step();
        load = 1'b0;
        wait_done();
        chk_cnt++; if (a_all !== {8{7'h00}}) $display("FAIL midrst_8888: got %h want all 00", a_all); else pass_cnt++;
        step();
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        test_reset();
        test_scan_order();
        test_blank_lz();
        test_back_to_back();
        test_blink();
        test_mask();
        test_reset_mid_scan();
        repeat (2) step();
        chk_cnt++; if (exp_q0.size() != 0 || exp_q1.size() != 0)
            $display("FAIL sb_drain: got %0d %0d pending want 0 0", exp_q0.size(), exp_q1.size()); else pass_cnt++;
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
